// File: rtl/floor_call_if.sv
// Floor call dispatcher bus: button/floor inputs and
// request/status outputs toward the elevator core.
interface floor_call_if #(
  parameter int NUM_FLOORS = 10
);
  logic [NUM_FLOORS-1:0] btn;
  logic [3:0]            cur_floor;
  logic [NUM_FLOORS-1:0] req;
  logic [NUM_FLOORS-1:0] pending;
  logic [3:0]            target;
  logic                  target_valid;
  logic                  dir_up;

  modport master (
    output btn, cur_floor,
    input  req, pending, target, target_valid, dir_up
  );

  modport slave (
    input  btn, cur_floor,
    output req, pending, target, target_valid, dir_up
  );
endinterface

// File: rtl/floor_call_dispatcher.sv
// Latches floor calls, picks targets in SCAN order and
// drives a registered one-hot request to the elevator.
module floor_call_dispatcher #(
  parameter int NUM_FLOORS   = 10,
  parameter int DWELL_CYCLES = 4
) (
  input logic       clk,
  input logic       reset,
  floor_call_if.slave bus
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SERVE, DWELL} state_t;

  state_t                state;
  logic [NUM_FLOORS-1:0] btn_q;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] req;
  logic [3:0]            target;
  logic                  target_valid;
  logic                  dir_up;
  logic [CW-1:0]         cnt;

  logic                  cur_ok;
  logic [NUM_FLOORS-1:0] cur_oh;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] mask;
  logic [NUM_FLOORS-1:0] take;
  logic                  reload;
  logic                  arrive;
  logic                  up_hit;
  logic                  dn_hit;
  logic [3:0]            up_f;
  logic [3:0]            dn_f;
  logic                  sel_hit;
  logic                  sel_dir;
  logic [3:0]            sel_f;
  logic                  re_hit;
  logic [3:0]            re_f;

  function automatic logic [NUM_FLOORS-1:0] onehot(
    input logic [3:0] f
  );
    return NUM_FLOORS'(1) << f;
  endfunction

  // Nearest pending floor above and below the car.
  always_comb begin
    cur_ok = int'(bus.cur_floor) < NUM_FLOORS;
    up_hit = 1'b0;
    up_f   = 4'd0;
    dn_hit = 1'b0;
    dn_f   = 4'd0;
    cur_oh = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && 4'(i) > bus.cur_floor) begin
        up_hit = 1'b1;
        up_f   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_oh[i] = cur_ok && (bus.cur_floor == 4'(i));
      if (pending[i] && 4'(i) < bus.cur_floor) begin
        dn_hit = 1'b1;
        dn_f   = 4'(i);
      end
    end
  end

  // Press filtering, SCAN selection and retarget choice.
  always_comb begin
    press  = bus.btn & ~btn_q;
    mask   = (state == SERVE) ? '0 : cur_oh;
    take   = press & ~pending & ~mask;
    reload = (state == DWELL) && |(press & cur_oh);
    arrive = (bus.cur_floor == target);
    sel_hit = 1'b1;
    sel_dir = dir_up;
    sel_f   = bus.cur_floor;
    if (dir_up ? up_hit : dn_hit) begin
      sel_f = dir_up ? up_f : dn_f;
    end else if (dir_up ? dn_hit : up_hit) begin
      sel_f   = dir_up ? dn_f : up_f;
      sel_dir = !dir_up;
    end else if (!(|(pending & cur_oh))) begin
      sel_hit = 1'b0;
    end
    re_f   = dir_up ? up_f : dn_f;
    re_hit = dir_up ? (up_hit && up_f < target)
                    : (dn_hit && dn_f > target);
  end

  // Dispatcher state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      btn_q        <= bus.btn;
      pending      <= '0;
      req          <= '0;
      target       <= 4'd0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
      cnt          <= '0;
    end else begin
      btn_q   <= bus.btn;
      pending <= pending | take;
      unique case (state)
        IDLE: begin
          if (cur_ok && |pending && sel_hit) begin
            target       <= sel_f;
            dir_up       <= sel_dir;
            req          <= onehot(sel_f);
            target_valid <= 1'b1;
            state        <= SERVE;
          end
        end
        SERVE: begin
          if (arrive) begin
            pending      <= (pending | take) & ~onehot(target);
            req          <= '0;
            target_valid <= 1'b0;
            cnt          <= DWELL_LAST;
            state        <= DWELL;
          end else if (cur_ok && re_hit) begin
            target <= re_f;
            req    <= onehot(re_f);
          end
        end
        DWELL: begin
          if (reload) begin
            cnt <= DWELL_LAST;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req          = req;
  assign bus.pending      = pending;
  assign bus.target       = target;
  assign bus.target_valid = target_valid;
  assign bus.dir_up       = dir_up;

endmodule

// File: tb/tb_floor_call_dispatcher.sv
// Random and directed stimulus for floor_call_dispatcher,
// checked by a queue-fed monitor against a floor-level model.
module tb_floor_call_dispatcher;

  localparam int N = 10;
  localparam int D = 4;
  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_DWELL = 2;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] pending;
    logic [3:0]   target;
    logic         tv;
    logic         dir;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  floor_call_if #(.NUM_FLOORS(N)) bus ();

  floor_call_dispatcher #(
    .NUM_FLOORS(N),
    .DWELL_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  int   served[$];

  bit m_pend[N];
  bit m_old[N];
  bit m_bq[N];
  int m_st = S_IDLE;
  int m_tgt = 0;
  int m_cnt = 0;
  bit m_tv = 0;
  bit m_dir = 1;

  bit           drv_rst = 1;
  logic [N-1:0] drv_btn = '0;
  int           drv_cur = 0;
  int           saved_cur = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int above(input int c);
    for (int f = c + 1; f < N; f++) if (m_old[f]) return f;
    return -1;
  endfunction

  function automatic int below(input int c);
    for (int f = c - 1; f >= 0; f--) if (m_old[f]) return f;
    return -1;
  endfunction

  function automatic bit any_old();
    for (int f = 0; f < N; f++) if (m_old[f]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the floor-level reference behaviour.
  task automatic model_step(input bit rst, input logic [N-1:0] b,
                            input int c);
    bit valid;
    bit reload;
    int a;
    int bl;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_bq[i]   = b[i];
      end
      m_st = S_IDLE; m_tgt = 0; m_cnt = 0; m_tv = 0; m_dir = 1;
      return;
    end
    valid  = (c < N);
    m_old  = m_pend;
    reload = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i] && !m_bq[i]) begin
        if (m_st != S_SERVE && i == c) begin
          if (m_st == S_DWELL) reload = 1;
        end else begin
          m_pend[i] = 1;
        end
      end
    end
    case (m_st)
      S_IDLE: begin
        if (valid && any_old()) begin
          a  = above(c);
          bl = below(c);
          if (m_dir && a >= 0) m_tgt = a;
          else if (m_dir && bl >= 0) begin m_tgt = bl; m_dir = 0; end
          else if (!m_dir && bl >= 0) m_tgt = bl;
          else if (!m_dir && a >= 0) begin m_tgt = a; m_dir = 1; end
          else m_tgt = c;
          m_tv = 1;
          m_st = S_SERVE;
        end
      end
      S_SERVE: begin
        if (c == m_tgt) begin
          m_pend[m_tgt] = 0;
          m_tv  = 0;
          m_cnt = D - 1;
          m_st  = S_DWELL;
        end else if (valid) begin
          a  = above(c);
          bl = below(c);
          if (m_dir && a >= 0 && a < m_tgt) m_tgt = a;
          else if (!m_dir && bl >= 0 && bl > m_tgt) m_tgt = bl;
        end
      end
      default: begin
        if (reload) m_cnt = D - 1;
        else if (m_cnt == 0) m_st = S_IDLE;
        else m_cnt--;
      end
    endcase
    for (int i = 0; i < N; i++) m_bq[i] = b[i];
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.req     = m_tv ? (N'(1) << m_tgt) : '0;
    e.pending = '0;
    for (int i = 0; i < N; i++) e.pending[i] = m_pend[i];
    e.target  = 4'(m_tgt);
    e.tv      = m_tv;
    e.dir     = m_dir;
    return e;
  endfunction

  // Drive one cycle and queue the expected post-edge outputs.
  task automatic tick();
    exp_t e;
    bus.btn       = drv_btn;
    bus.cur_floor = 4'(drv_cur);
    reset         = drv_rst;
    model_step(drv_rst, drv_btn, drv_cur);
    e = snapshot();
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  task automatic do_reset(input int cur);
    drv_rst = 1; drv_btn = '0; drv_cur = cur;
    tick(); tick();
    drv_rst = 0;
    served.delete();
  endtask

  // Car follows the model's target one floor at a time.
  task automatic run(input int n, input int pmove, input bit rnd);
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        for (int i = 0; i < N; i++)
          drv_btn[i] = ($urandom_range(0, 11) == 0);
        drv_rst = ($urandom_range(0, 599) == 0);
        if (drv_cur < N && $urandom_range(0, 99) < 2) begin
          saved_cur = drv_cur;
          drv_cur   = 15;
        end else if (drv_cur >= N && $urandom_range(0, 99) < 30) begin
          drv_cur = saved_cur;
        end
      end
      if (m_tv && drv_cur < N && drv_cur != m_tgt &&
          $urandom_range(0, 99) < pmove)
        drv_cur = (m_tgt > drv_cur) ? drv_cur + 1 : drv_cur - 1;
      tick();
    end
    drv_rst = 0;
    drv_btn = '0;
  endtask

  // Monitor: compare every presented output cycle.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("req", int'(bus.req), int'(e.req));
      chk("pending", int'(bus.pending), int'(e.pending));
      chk("target", int'(bus.target), int'(e.target));
      chk("target_valid", int'(bus.target_valid), int'(e.tv));
      chk("dir_up", int'(bus.dir_up), int'(e.dir));
    end
    if (reset === 1'b0 && bus.target_valid === 1'b1 &&
        bus.cur_floor == bus.target)
      served.push_back(int'(bus.target));
  end

  int scan_exp[3] = '{7, 9, 2};
  int first_req;

  initial begin
    // Button held through reset is not a press.
    drv_rst = 1; drv_btn = 10'h004; drv_cur = 0;
    repeat (3) tick();
    drv_rst = 0;
    repeat (5) begin
      tick();
      chk("hold_pending", int'(bus.pending), 0);
      chk("hold_req", int'(bus.req), 0);
    end

    // Single call from floor 0 to floor 3.
    do_reset(0);
    tick();
    drv_btn = 10'h008; tick();
    chk("single_pend", int'(bus.pending), 'h008);
    chk("single_req0", int'(bus.req), 0);
    drv_btn = '0; tick();
    chk("single_req", int'(bus.req), 'h008);
    chk("single_tgt", int'(bus.target), 3);
    drv_cur = 3; tick();
    chk("single_arr_req", int'(bus.req), 0);
    chk("single_arr_pend", int'(bus.pending), 0);
    drv_btn = 10'h040; tick();
    drv_btn = '0;
    repeat (8) tick();

    // SCAN ordering 7, 9 then 2.
    do_reset(5);
    drv_btn = 10'h284; tick();
    drv_btn = '0;
    run(80, 50, 0);
    chk("scan_count", served.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("scan_order", (i < served.size()) ? served[i] : -1,
          scan_exp[i]);
    chk("scan_dir", int'(bus.dir_up), 0);
    chk("scan_empty", int'(bus.pending), 0);

    // Retarget from 8 to 4 while at floor 2.
    do_reset(2);
    drv_btn = 10'h100; tick();
    drv_btn = '0; tick(); tick();
    chk("rt_tgt8", int'(bus.target), 8);
    drv_btn = 10'h010; tick();
    drv_btn = '0; tick();
    chk("rt_tgt", int'(bus.target), 4);
    chk("rt_req", int'(bus.req), 'h010);
    chk("rt_pend8", int'(bus.pending[8]), 1);
    run(60, 50, 0);

    // Press current floor in DWELL restarts the dwell.
    do_reset(0);
    drv_btn = 10'h002; tick();
    drv_btn = '0; tick();
    drv_cur = 1; tick();
    tick();
    drv_btn = 10'h012; tick();
    chk("dw_pend1", int'(bus.pending[1]), 0);
    chk("dw_pend4", int'(bus.pending[4]), 1);
    drv_btn = '0;
    first_req = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (first_req == 0 && bus.req != '0) first_req = k;
    end
    chk("dw_restart", first_req, 5);

    // Press on target in its arrival cycle: clear wins.
    drv_cur = 2; tick();
    drv_cur = 3; tick();
    drv_cur = 4; drv_btn = 10'h010; tick();
    chk("arr_clear", int'(bus.pending[4]), 0);
    drv_btn = '0;
    repeat (6) tick();

    // Invalid floor in IDLE and in SERVE.
    do_reset(15);
    drv_btn = 10'h004; tick();
    drv_btn = '0;
    repeat (4) tick();
    chk("inv_idle_req", int'(bus.req), 0);
    chk("inv_idle_pend", int'(bus.pending), 'h004);
    drv_cur = 0;
    drv_btn = 10'h048; tick();
    drv_btn = '0; tick(); tick();
    drv_cur = 15;
    repeat (6) begin
      tick();
      chk("inv_serve_tv", int'(bus.target_valid), 1);
    end
    drv_cur = 1; tick();

    // Reset in the middle of SERVE.
    drv_rst = 1; drv_btn = 10'h200; tick();
    chk("rst_req", int'(bus.req), 0);
    chk("rst_pend", int'(bus.pending), 0);
    chk("rst_tgt", int'(bus.target), 0);
    chk("rst_tv", int'(bus.target_valid), 0);
    chk("rst_dir", int'(bus.dir_up), 1);
    drv_rst = 0; drv_btn = '0;
    tick();

    // Randomized traffic.
    do_reset(0);
    run(4000, 40, 1);
    repeat (20) tick();

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floor_call_dispatcher.md
Name: floor_call_dispatcher

Overview:
- Producer side of the elevator floor-request inputs: turns raw call buttons for floors 0-9 into a single registered one-hot request for the elevator FSM.
- Sits between the board buttons/switches and the elevator core. Takes the elevator's current floor (its floorLED code) back as the arrival indication.
- Latches pending calls and selects targets in SCAN order. Clears each call when the elevator reaches that floor, then holds a door-dwell interval.

Parameters:
- NUM_FLOORS, 10, number of floors and call buttons. Floor codes are 0..NUM_FLOORS-1.
- DWELL_CYCLES, 4, clock cycles spent in DWELL after an arrival. Must be at least 1.

Ports:
- clk  input  1  system clock. All state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  NUM_FLOORS  raw call buttons, already synchronous to clk. Bit i is floor i.
- cur_floor  input  4  elevator's current floor code (its floorLED). Values >= NUM_FLOORS are invalid.
- req  output  NUM_FLOORS  registered one-hot request to the elevator. Bit i drives the elevator's in<i>. All-zero means no request.
- pending  output  NUM_FLOORS  latched outstanding calls.
- target  output  4  floor currently being served.
- target_valid  output  1  high while in SERVE.
- dir_up  output  1  SCAN direction. 1 = up, 0 = down.

Behaviour:
- Reset values:
  - req=0, pending=0, target=0, target_valid=0, dir_up=1, state=IDLE, dwell counter=0.
  - The btn history register loads the current btn value during reset, so buttons held through reset do not register as presses.
- Press detection:
  - A press on floor i is btn[i]=1 with the registered btn_q[i]=0.
  - pending[i] is set at the edge where the press is sampled.
  - Holding a button produces only one press.
- Press ignore/merge rules:
  - Press on floor i with i == cur_floor while in IDLE or DWELL: ignored, pending is not set. In DWELL, the dwell counter reloads to DWELL_CYCLES-1.
  - Press on a floor whose pending bit is already set: no effect.
- IDLE:
  - pending == 0: stay in IDLE, req=0.
  - Otherwise select a target, register target, set req=onehot(target) and target_valid=1, and go to SERVE on the next edge.
  - Press-to-req latency is 2 edges.
- Selection (SCAN):
  - dir_up=1: pick the lowest pending floor > cur_floor. If there is none, flip dir_up to 0 and pick the highest pending floor < cur_floor.
  - dir_up=0: symmetric. Pick the highest pending floor < cur_floor; otherwise flip to 1 and pick the lowest pending floor > cur_floor.
  - cur_floor invalid: stay in IDLE; pending is still latched.
- SERVE:
  - req holds onehot(target).
  - Retarget: a new pending floor lying strictly between cur_floor and target in the current direction replaces target on the next edge. req updates on the same edge, dir is unchanged.
  - Arrival (cur_floor == target): clear pending[target], req=0, target_valid=0, load dwell counter with DWELL_CYCLES-1, go to DWELL.
  - A press on the target floor in the arrival cycle: the clear wins.
  - cur_floor invalid: never counts as arrival; hold the current state.
- DWELL:
  - req=0.
  - The counter decrements each cycle. When the counter is 0, go to IDLE on the next edge.
  - Presses for other floors are latched normally during DWELL.
- Reset mid-operation: any state returns to IDLE on the next edge with all reset values above, pending cleared.
- target is a 4-bit register. Floor index comparisons are unsigned.

Test Plan:
- Reset hold:
  - Stimulus: btn=10'h004 held through reset; reset deasserted.
  - Required: pending stays 0 and req stays 0 for 5 cycles.
- Single call:
  - Stimulus: cur_floor=0; pulse btn[3] for 1 cycle at edge k.
  - Required: pending=10'h008 after edge k; req=10'h008 and target=3 after edge k+1.
  - Then: drive cur_floor=3 → req=0, pending=0, DWELL for 4 cycles, then IDLE.
- SCAN ordering:
  - Stimulus: cur_floor=5, dir_up=1; press floors 2, 7 and 9 together.
  - Required: serves 7, then 9, then dir_up flips to 0 and serves 2.
- Retarget:
  - Stimulus: in SERVE with target=8, cur_floor=2; press floor 4.
  - Required: target=4 and req=10'h010 one edge later; floor 8 stays pending.
- Boundary presses:
  - Stimulus: press the current floor while in DWELL; separately, press the target floor in the arrival cycle.
  - Required: the first causes no pending bit and the dwell restarts. The second leaves pending[target]=0.
- Invalid floor and mid-operation reset:
  - Stimulus: cur_floor=4'hF with pending floors present; then assert reset mid-SERVE.
  - Required: no arrival is ever detected with cur_floor=4'hF. After the reset edge, all outputs return to their reset values.
